// File: rtl/cordic_sched_pkg.sv
// Shared constants and FSM encoding for the CORDIC request scheduler.
// Float constants are IEEE-754 single precision.
package cordic_sched_pkg;

   localparam int unsigned FLOAT_W    = 32;
   localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FLOAT_ONE  = 32'h3F80_0000;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// i_ptr must be below N_REQ.
module cordic_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [ID_W-1:0]  o_gnt_id,
   output logic             o_any
);

   localparam logic [ID_W:0] N_W = (ID_W + 1)'(N_REQ);

   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [ID_W-1:0]    w_off;
   logic [ID_W:0]      w_sum;
   logic               w_found;

   // Rotate so that bit 0 is the requester at i_ptr, then find the first set bit.
   always_comb begin
      w_dbl   = {i_req, i_req} >> i_ptr;
      w_rot   = w_dbl[N_REQ-1:0];
      w_off   = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = ID_W'(k);
         end
      end
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= N_W) begin
         w_sum = w_sum - N_W;
      end
      o_gnt_id = w_sum[ID_W-1:0];
      o_any    = w_found;
   end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one CORDIC among N_REQ requesters, with a WAIT timeout
// that returns a NaN error response if the CORDIC never signals done.
module cordic_sched
   import cordic_sched_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req_valid,
   input  logic [FLOAT_W*N_REQ-1:0] i_req_angle,
   output logic [N_REQ-1:0]         o_req_ready,
   output logic                     o_resp_valid,
   output logic [ID_W-1:0]          o_resp_id,
   output logic [FLOAT_W-1:0]       o_resp_cos,
   output logic [FLOAT_W-1:0]       o_resp_sin,
   output logic                     o_resp_err,
   output logic                     o_busy,
   output logic                     o_cor_valid_in,
   output logic [FLOAT_W-1:0]       o_cor_angle,
   input  logic                     i_cor_done,
   input  logic [FLOAT_W-1:0]       i_cor_cos,
   input  logic [FLOAT_W-1:0]       i_cor_sin
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

   sched_state_e r_state;
   sched_state_e w_state_nxt;

   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_gnt_id;
   logic [CNT_W-1:0]   r_cnt;
   logic [ID_W-1:0]    w_pick_id;
   logic               w_pick_any;
   logic [FLOAT_W-1:0] w_pick_angle;
   logic               w_take;
   logic               w_timeout;
   logic [N_REQ-1:0]   w_req_ready_d;
   logic               w_cor_valid_d;
   logic               w_resp_valid_d;
   logic               w_busy_d;

   cordic_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .i_req    (i_req_valid),
      .i_ptr    (r_rr_ptr),
      .o_gnt_id (w_pick_id),
      .o_any    (w_pick_any)
   );

   always_comb begin
      w_pick_angle = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_pick_id == ID_W'(i)) begin
            w_pick_angle = i_req_angle[i*FLOAT_W +: FLOAT_W];
         end
      end
   end

   assign w_take    = (r_state == StIdle) && w_pick_any;
   assign w_timeout = (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A done pulse outside WAIT is never looked at; done beats a same-cycle timeout.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_pick_any) w_state_nxt = StIssue;
         StIssue: w_state_nxt = StWait;
         StWait:  if (i_cor_done || w_timeout) w_state_nxt = StResp;
         StResp:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Outputs are decoded from the next state and registered below.
   always_comb begin
      w_req_ready_d  = '0;
      w_cor_valid_d  = 1'b0;
      w_resp_valid_d = 1'b0;
      w_busy_d       = (w_state_nxt != StIdle);
      unique case (w_state_nxt)
         StIssue: begin
            w_cor_valid_d = 1'b1;
            w_req_ready_d = N_REQ'(1) << w_pick_id;
         end
         StResp:  w_resp_valid_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rr_ptr       <= '0;
         r_gnt_id       <= '0;
         r_cnt          <= '0;
         o_req_ready    <= '0;
         o_cor_valid_in <= 1'b0;
         o_cor_angle    <= '0;
         o_busy         <= 1'b0;
         o_resp_valid   <= 1'b0;
         o_resp_id      <= '0;
         o_resp_cos     <= '0;
         o_resp_sin     <= '0;
         o_resp_err     <= 1'b0;
      end else begin
         o_req_ready    <= w_req_ready_d;
         o_cor_valid_in <= w_cor_valid_d;
         o_busy         <= w_busy_d;
         o_resp_valid   <= w_resp_valid_d;

         if (w_take) begin
            r_gnt_id    <= w_pick_id;
            o_cor_angle <= w_pick_angle;
         end

         if (r_state == StIssue) begin
            r_rr_ptr <= (r_gnt_id == ID_LAST) ? '0 : r_gnt_id + 1'b1;
            r_cnt    <= '0;
         end else if (r_state == StWait) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if ((r_state == StWait) && (w_state_nxt == StResp)) begin
            o_resp_id <= r_gnt_id;
            if (i_cor_done) begin
               o_resp_cos <= i_cor_cos;
               o_resp_sin <= i_cor_sin;
               o_resp_err <= 1'b0;
            end else begin
               o_resp_cos <= FLOAT_QNAN;
               o_resp_sin <= FLOAT_QNAN;
               o_resp_err <= 1'b1;
            end
         end
      end
   end

endmodule
